// File: rtl/sys_bus_master_pkg.sv
// sys_bus_master shared types
// FSM state encoding and response bundle
package sys_bus_master_pkg;

  // widest bus data width the response bundle carries
  localparam int RSP_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [RSP_DW-1:0] rdata;
    logic              err;
    logic              tmo;
  } rsp_t;

  localparam rsp_t RSP_TIMEOUT = '{rdata: '0, err: 1'b1, tmo: 1'b1};

endpackage

// File: rtl/sys_bus_if.sv
// sys_bus initiator/responder signal bundle
// one strobe per transfer, ack/err/rdata returned by responder
interface sys_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic            wen;
  logic            ren;
  logic            ack;
  logic            err;
  logic [DW-1:0]   rdata;

  modport m (
    output addr, wdata, sel, wen, ren,
    input  ack, err, rdata
  );

  modport s (
    input  addr, wdata, sel, wen, ren,
    output ack, err, rdata
  );

endinterface

// File: rtl/sys_bus_master.sv
// sys_bus_master: single-outstanding bus initiator
// command in, one strobe out, ack or timeout back as a response
module sys_bus_master
  import sys_bus_master_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic            cmd_wr,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_tmo,
  sys_bus_if.m            bus
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  state_e          state_q, state_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic            wr_q, wr_d;
  logic            wen_q, wen_d;
  logic            ren_q, ren_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rsp_t            rsp_q, rsp_d;
  rsp_t            rsp_ack;

  // response captured on ack; write data never leaks into rdata
  always_comb begin
    rsp_ack       = '0;
    rsp_ack.rdata = wr_q ? '0 : RSP_DW'(bus.rdata);
    rsp_ack.err   = bus.err;
    rsp_ack.tmo   = 1'b0;
  end

  // next-state, strobe and response logic
  always_comb begin
    state_d   = state_q;
    cmd_rdy_d = cmd_rdy_q;
    rsp_vld_d = rsp_vld_q;
    wr_d      = wr_q;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rsp_d     = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_vld && cmd_rdy_q) begin
          wr_d      = cmd_wr;
          wen_d     = cmd_wr;
          ren_d     = !cmd_wr;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          sel_d     = cmd_sel;
          cmd_rdy_d = 1'b0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (bus.ack) begin
          rsp_d     = rsp_ack;
          rsp_vld_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.ack) begin
          rsp_d     = rsp_ack;
          rsp_vld_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TMO_LAST) begin
            rsp_d     = RSP_TIMEOUT;
            rsp_vld_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          cmd_rdy_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cmd_rdy_d = 1'b1;
        rsp_vld_d = 1'b0;
      end
    endcase
  end

  // state and registered outputs; reset drops any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_rdy_q <= 1'b1;
      rsp_vld_q <= 1'b0;
      wr_q      <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_rdy_q <= cmd_rdy_d;
      rsp_vld_q <= rsp_vld_d;
      wr_q      <= wr_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rsp_q     <= rsp_d;
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = DW'(rsp_q.rdata);
  assign rsp_err   = rsp_q.err;
  assign rsp_tmo   = rsp_q.tmo;

  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.sel   = sel_q;
  assign bus.wen   = wen_q;
  assign bus.ren   = ren_q;

endmodule

// File: tb/tb_sys_bus_master.sv
// tb_sys_bus_master: table-driven commands, scripted responder,
// scoreboard of expected responses and latencies
module tb_sys_bus_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tmo;

  sys_bus_if #(.AW(32), .DW(32)) bus_if ();

  sys_bus_master #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_sel   (cmd_sel),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_tmo   (rsp_tmo),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // scripted responder: ack r_delay cycles after the strobe
  // (-1 never acks, 0 acks inside the strobe cycle); r_tie holds ack=err=1
  int          r_delay = -1;
  logic        r_err = 1'b0;
  logic [31:0] r_rdata = '0;
  logic        r_tie = 1'b0;
  int          rem = 0;
  int          strobe_cyc = 0;
  int          strobes = 0;
  int          both_hi = 0;
  int          hold_bad = 0;
  logic [31:0] cur_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      rem = 0;
      bus_if.ack = 1'b0;
      bus_if.err = 1'b0;
      bus_if.rdata = '0;
    end else begin
      bus_if.ack = r_tie;
      bus_if.err = r_tie;
      bus_if.rdata = r_rdata;
      if (bus_if.wen && bus_if.ren) both_hi++;
      if (rem > 0) begin
        if (bus_if.addr !== cur_addr) hold_bad++;
        rem--;
        if (rem == 0) begin
          bus_if.ack = 1'b1;
          bus_if.err = r_err;
        end
      end
      if (bus_if.wen || bus_if.ren) begin
        strobes++;
        strobe_cyc = cyc;
        cur_addr = bus_if.addr;
        if (r_delay == 0) begin
          bus_if.ack = 1'b1;
          bus_if.err = r_err;
        end else if (r_delay > 0) begin
          rem = r_delay;
        end
      end
    end
  end

  // count every response the DUT raises
  int   rises = 0;
  logic vld_prev = 1'b0;
  always @(negedge clk) begin
    if (rsp_vld && !vld_prev) rises++;
    vld_prev = rsp_vld;
  end

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          delay;
    logic        tie;
    logic        err;
    logic [31:0] rdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   issued = 0;
  int   popped = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input logic wr, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [3:0] sel, input int delay,
    input logic tie, input logic err, input logic [31:0] rdata,
    input int hold, input logic [31:0] er, input logic ee,
    input logic et, input int el);
    vec_t v;
    v.name = nm; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.sel = sel; v.delay = delay; v.tie = tie; v.err = err;
    v.rdata = rdata; v.hold = hold; v.exp_rdata = er;
    v.exp_err = ee; v.exp_tmo = et; v.exp_lat = el;
    return v;
  endfunction

  // drive one command; strobe and bus fields checked at accept+1
  task automatic issue(input vec_t v, input bit push);
    int n;
    exp_t e;
    r_delay = v.delay;
    r_err = v.err;
    r_rdata = v.rdata;
    r_tie = v.tie;
    n = 0;
    while (!cmd_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, "_rdy"}, 64'(cmd_rdy), 64'd1);
    cmd_vld = 1'b1;
    cmd_wr = v.wr;
    cmd_addr = v.addr;
    cmd_wdata = v.wdata;
    cmd_sel = v.sel;
    @(negedge clk);
    cmd_vld = 1'b0;
    issued++;
    if (push) begin
      e.rdata = v.exp_rdata;
      e.err = v.exp_err;
      e.tmo = v.exp_tmo;
      e.lat = v.exp_lat;
      sb.push_back(e);
    end
    chk({v.name, "_strobe"}, 64'({bus_if.wen, bus_if.ren}),
        64'({v.wr, !v.wr}));
    chk({v.name, "_busfld"},
        64'({bus_if.addr[15:0], bus_if.sel, bus_if.wdata[27:0]}),
        64'({v.addr[15:0], v.sel, v.wdata[27:0]}));
  endtask

  // wait for a response, compare against the scoreboard, then consume
  task automatic wait_rsp(input vec_t v);
    int n;
    int bad;
    exp_t e;
    logic [33:0] snap;
    n = 0;
    while (!rsp_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_vld) begin
      chk({v.name, "_rsp_timeout"}, 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      chk({v.name, "_unexpected_rsp"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      popped++;
      chk({v.name, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      chk({v.name, "_err_tmo"}, 64'({rsp_err, rsp_tmo}),
          64'({e.err, e.tmo}));
      chk({v.name, "_lat"}, 64'(cyc - strobe_cyc), 64'(e.lat));
      if (v.hold > 0) begin
        snap = {rsp_rdata, rsp_err, rsp_tmo};
        bad = 0;
        cmd_vld = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
          @(negedge clk);
          if (cmd_rdy !== 1'b0 || rsp_vld !== 1'b1) bad++;
          if ({rsp_rdata, rsp_err, rsp_tmo} !== snap) bad++;
        end
        cmd_vld = 1'b0;
        chk({v.name, "_hold"}, 64'(bad), 64'd0);
      end
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      chk({v.name, "_done"}, 64'({rsp_vld, cmd_rdy}), 64'b01);
    end
    n = 0;
    while (rem > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    r_tie = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[12];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //             name    wr    addr          wdata         sel    dly tie err rdata        hold exp_rdata    ee    et    lat
    vecs[0]  = mk("wr_d1", 1'b1, 32'h100, 32'h11223344, 4'hF, 1, 1'b0, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 1'b0, 1'b0, 2);
    vecs[1]  = mk("rd_40", 1'b0, 32'h40, 32'h0, 4'hF, 4, 1'b0, 1'b0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 1'b0, 5);
    vecs[2]  = mk("rd_err0", 1'b0, 32'h44, 32'h0, 4'hF, 0, 1'b0, 1'b1, 32'h5555AAAA, 0, 32'h5555AAAA, 1'b1, 1'b0, 1);
    vecs[3]  = mk("wr_d0", 1'b1, 32'h48, 32'hCAFE0001, 4'h1, 0, 1'b0, 1'b0, 32'h12345678, 0, 32'h0, 1'b0, 1'b0, 1);
    vecs[4]  = mk("rd_d3", 1'b0, 32'h4C, 32'h0, 4'hC, 3, 1'b0, 1'b0, 32'h0BADF00D, 0, 32'h0BADF00D, 1'b0, 1'b0, 4);
    vecs[5]  = mk("rd_tmo", 1'b0, 32'h50, 32'h0, 4'hF, -1, 1'b0, 1'b0, 32'h99999999, 0, 32'h0, 1'b1, 1'b1, 5);
    vecs[6]  = mk("wr_late5", 1'b1, 32'h54, 32'h0F0F0F0F, 4'hF, 5, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b1, 1'b1, 5);
    vecs[7]  = mk("rd_late7", 1'b0, 32'h58, 32'h0, 4'hF, 7, 1'b0, 1'b0, 32'h31415926, 0, 32'h0, 1'b1, 1'b1, 5);
    vecs[8]  = mk("rd_after", 1'b0, 32'h5C, 32'h0, 4'hF, 2, 1'b0, 1'b0, 32'h600DCAFE, 0, 32'h600DCAFE, 1'b0, 1'b0, 3);
    vecs[9]  = mk("rd_err1", 1'b0, 32'h60, 32'h0, 4'h3, 1, 1'b0, 1'b1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b1, 1'b0, 2);
    vecs[10] = mk("rd_tie", 1'b0, 32'h64, 32'h0, 4'hF, -1, 1'b1, 1'b1, 32'h77778888, 0, 32'h77778888, 1'b1, 1'b0, 1);
    vecs[11] = mk("rd_bp", 1'b0, 32'h80, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h13579BDF, 10, 32'h13579BDF, 1'b0, 1'b0, 2);

    rst = 1'b1;
    cmd_vld = 1'b0;
    cmd_wr = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_sel = '0;
    rsp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hs", 64'({cmd_rdy, rsp_vld, rsp_err, rsp_tmo}), 64'b1000);
    chk("rst_bus", 64'({bus_if.wen, bus_if.ren, bus_if.addr, rsp_rdata}),
        64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(cmd_rdy), 64'd1);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], 1'b1);
      wait_rsp(vecs[i]);
    end

    // reset while waiting on an ack: no response may ever appear
    rv = mk("rst_mid", 1'b0, 32'h200, 32'h0, 4'hF, -1, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 0);
    issue(rv, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_hs", 64'({cmd_rdy, rsp_vld, rsp_err, rsp_tmo}), 64'b1000);
    chk("rst_mid_bus", 64'({bus_if.wen, bus_if.ren, bus_if.addr, rsp_rdata}),
        64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_norsp", 64'(rsp_vld), 64'd0);

    issue(vecs[8], 1'b1);
    wait_rsp(vecs[8]);

    chk("rsp_count", 64'(rises), 64'(popped));
    chk("strobe_count", 64'(strobes), 64'(issued));
    chk("wen_ren_excl", 64'(both_hi), 64'd0);
    chk("addr_hold", 64'(hold_bad), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
